// File: rtl/imem_loader.sv
// Instruction memory loader: streams program bytes into a byte array, then serves
// 10-byte fetch windows combinationally once the load is complete.
module imem_loader #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        ld_restart,
    output logic [10:0] ld_count,
    output logic        mem_ready,
    input  logic [63:0] rd_addr,
    output logic [79:0] rd_data,
    output logic        rd_error,
    output logic        state_dbg
);

    localparam int          AW        = $clog2(MEM_BYTES);
    localparam logic [10:0] LAST_ADDR = 11'(MEM_BYTES - 1);
    localparam logic [79:0] NOP_WINDOW = {8'h10, 72'h0};

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] count_next;
    logic        wr_en;
    logic [7:0]  mem [MEM_BYTES];
    logic [64:0] win_addr;
    logic [79:0] window;

    // Load handshake: a byte transfers on a rising edge where ld_valid and ld_ready
    // are both 1; ld_ready never depends on ld_valid, and ld_restart overrides a transfer.
    always_comb begin
        state_next = state;
        count_next = ld_count;
        wr_en      = 1'b0;
        ld_ready   = 1'b0;
        unique case (state)
            S_LOAD: begin
                ld_ready = !reset;
                if (ld_restart) begin
                    count_next = '0;
                end else if (ld_valid && !reset) begin
                    wr_en      = 1'b1;
                    count_next = ld_count + 11'd1;
                    if (ld_last || ld_count == LAST_ADDR) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (ld_restart) begin
                    state_next = S_LOAD;
                    count_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_LOAD;
            ld_count <= '0;
        end else begin
            state    <= state_next;
            ld_count <= count_next;
        end
    end

    // Contents survive reset on purpose; ld_count masks stale bytes on the read side.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ld_count[AW-1:0]] <= ld_data;
        end
    end

    // A 65-bit sum lets a carry out of rd_addr+i count as out of range instead of wrapping.
    always_comb begin
        window   = '0;
        win_addr = '0;
        for (int i = 0; i < 10; i++) begin
            win_addr = {1'b0, rd_addr} + 65'(i);
            if (!win_addr[64] && win_addr[63:0] < 64'(ld_count)) begin
                window[79-8*i -: 8] = mem[win_addr[AW-1:0]];
            end
        end
    end

    assign mem_ready = (state == S_DONE);
    assign rd_error  = (rd_addr >= 64'(MEM_BYTES)) || !mem_ready;
    assign rd_data   = rd_error ? NOP_WINDOW : window;
    assign state_dbg = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven load vectors, directed corner sequences and
// randomized traffic checked against an array-based model of the loader.
module tb_imem_loader;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_restart = 1'b0;
    logic [10:0] ld_count;
    logic        mem_ready;
    logic [63:0] rd_addr = 64'h0;
    logic [79:0] rd_data;
    logic        rd_error;
    logic        state_dbg;

    imem_loader #(.MEM_BYTES(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_restart (ld_restart),
        .ld_count   (ld_count),
        .mem_ready  (mem_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_error   (rd_error),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: program image, bytes loaded, and whether the load finished.
    logic [7:0] m_mem [MB];
    int         m_count = 0;
    bit         m_done  = 1'b0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        int          exp_count;
        logic        exp_ready;
        logic        exp_mrdy;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    function automatic void model_step(logic v, logic [7:0] d, logic l, logic r);
        if (!m_done) begin
            if (r) begin
                m_count = 0;
            end else if (v) begin
                m_mem[m_count] = d;
                m_count++;
                if (l || m_count == MB) m_done = 1'b1;
            end
        end else if (r) begin
            m_done  = 1'b0;
            m_count = 0;
        end
    endfunction

    function automatic logic [79:0] model_read(logic [63:0] a);
        logic [79:0] r;
        logic [63:0] ai;
        if (a >= 64'(MB) || !m_done) return {8'h10, 72'h0};
        r = '0;
        for (int i = 0; i < 10; i++) begin
            ai = a + 64'(i);
            if (ai >= a && ai < 64'(m_count)) r[79-8*i -: 8] = m_mem[ai[9:0]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("ld_count", 80'(ld_count), 80'(m_count));
        check("ld_ready", 80'(ld_ready), 80'(!m_done && !reset));
        check("mem_ready", 80'(mem_ready), 80'(m_done));
        check("state_dbg", 80'(state_dbg), 80'(m_done));
    endtask

    task automatic check_read(input logic [63:0] a);
        @(negedge clk);
        rd_addr = a;
        #1;
        check("rd_data", rd_data, model_read(a));
        check("rd_error", 80'(rd_error), 80'(a >= 64'(MB) || !m_done));
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        ld_valid   = v;
        ld_data    = d;
        ld_last    = l;
        ld_restart = r;
        @(posedge clk);
        model_step(v, d, l, r);
        #1;
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        ld_restart = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        ld_restart = 1'b0;
        reset      = 1'b1;
        #1;
        m_count = 0;
        m_done  = 1'b0;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs();
    endtask

    task automatic apply_vec(input vec_t vv, input string tag);
        drive(vv.v, vv.d, vv.l, vv.r);
        check({tag, "_count"}, 80'(ld_count), 80'(vv.exp_count));
        check({tag, "_ready"}, 80'(ld_ready), 80'(vv.exp_ready));
        check({tag, "_mrdy"}, 80'(mem_ready), 80'(vv.exp_mrdy));
    endtask

    initial begin
        // Basic load with a pause mid-stream, ending on ld_last.
        vecs_a.push_back('{1'b1, 8'h10, 1'b0, 1'b0, 1, 1'b1, 1'b0});
        vecs_a.push_back('{1'b1, 8'h10, 1'b0, 1'b0, 2, 1'b1, 1'b0});
        vecs_a.push_back('{1'b0, 8'hEE, 1'b0, 1'b0, 2, 1'b1, 1'b0});
        vecs_a.push_back('{1'b0, 8'hEE, 1'b1, 1'b0, 2, 1'b1, 1'b0});
        vecs_a.push_back('{1'b0, 8'hEE, 1'b0, 1'b0, 2, 1'b1, 1'b0});
        vecs_a.push_back('{1'b1, 8'h20, 1'b0, 1'b0, 3, 1'b1, 1'b0});
        vecs_a.push_back('{1'b1, 8'h12, 1'b1, 1'b0, 4, 1'b0, 1'b1});
        // DONE ignores bytes, restart, restart beats a same-cycle byte, reload.
        vecs_b.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 4, 1'b0, 1'b1});
        vecs_b.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0});
        vecs_b.push_back('{1'b1, 8'hAA, 1'b0, 1'b1, 0, 1'b1, 1'b0});
        vecs_b.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 1'b0});
        vecs_b.push_back('{1'b1, 8'h66, 1'b1, 1'b0, 2, 0, 1'b1});

        do_reset();
        check_read(64'd0);

        foreach (vecs_a[i]) apply_vec(vecs_a[i], $sformatf("veca%0d", i));
        check_read(64'd0);
        check("basic_window", rd_data, 80'h10102012_00000000_0000);
        check("basic_err", 80'(rd_error), 80'd0);
        check_read(64'd3);
        check("tail_window", rd_data, {8'h12, 72'h0});

        foreach (vecs_b[i]) apply_vec(vecs_b[i], $sformatf("vecb%0d", i));
        check_read(64'd0);
        check("restart_window", rd_data, {8'h55, 8'h66, 64'h0});

        // Full-memory stream without ld_last.
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < MB; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("full_count", 80'(ld_count), 80'd1024);
        check("full_ready", 80'(ld_ready), 80'd0);
        check("full_mrdy", 80'(mem_ready), 80'd1);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        check("extra_count", 80'(ld_count), 80'd1024);
        check_read(64'd1020);
        check("edge_tail_zero", 80'(rd_data[47:0]), 80'd0);
        check("edge_err", 80'(rd_error), 80'd0);
        check_read(64'd1023);
        check_read(64'd1024);
        check("oob_window", rd_data, {8'h10, 72'h0});
        check("oob_err", 80'(rd_error), 80'd1);
        check_read(64'hFFFF_FFFF_FFFF_FFFB);
        check_read(64'd0);

        // Reset in the middle of a load, then a short reload.
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("async_count", 80'(ld_count), 80'd0);
        check("async_ready", 80'(ld_ready), 80'd0);
        do_reset();
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, 1'b1, 1'b0);
        check("reload_count", 80'(ld_count), 80'd2);
        check_read(64'd0);
        check("reload_window", rd_data, {8'hA1, 8'hA2, 64'h0});
        check_read(64'd2);
        check("stale_window", rd_data, 80'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 70, 8'($urandom),
                      $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
            end
            case ($urandom_range(0, 3))
                0: check_read(64'($urandom_range(0, 1100)));
                1: check_read({$urandom, $urandom});
                2: check_read(64'($urandom_range(0, 20)));
                default: ;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the instruction memory size in bytes.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, the asynchronous, active-high reset.
REQ-004 SHALL have port ld_valid, input, 1, meaning the load byte on ld_data is offered.
REQ-005 SHALL have port ld_data, input, 8, meaning the program byte to store at the current write pointer.
REQ-006 SHALL have port ld_last, input, 1, meaning the offered byte is the final program byte.
REQ-007 SHALL have port ld_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 SHALL have port ld_restart, input, 1, a one-cycle request to begin a new load from address 0.
REQ-009 SHALL have port ld_count, output, 11, meaning the number of bytes loaded so far.
REQ-010 SHALL have port mem_ready, output, 1, meaning the program is loaded and fetch reads are valid.
REQ-011 SHALL have port rd_addr, input, 64, meaning the fetch PC.
REQ-012 SHALL have port rd_data, output, 80, meaning the 10-byte window at rd_addr, with rd_data[79:72] holding byte rd_addr.
REQ-013 SHALL have port rd_error, output, 1, meaning the fetch access is invalid (imem_error).

Function
REQ-014 SHALL implement the FSM states LOAD and DONE.
REQ-015 In LOAD, ld_ready SHALL be 1; in DONE, ld_ready SHALL be 0.
REQ-016 A byte SHALL be accepted only on a cycle where ld_valid=1 and ld_ready=1.
REQ-017 When a byte is accepted, mem[ld_count] SHALL be written with ld_data and ld_count SHALL increment by 1, with both taking effect on the same edge.
REQ-018 LOAD SHALL go to DONE on the edge that accepts a byte with ld_last=1.
REQ-019 LOAD SHALL go to DONE on the edge that accepts the byte at address MEM_BYTES-1, regardless of ld_last; no byte SHALL ever be written at an address of MEM_BYTES or above.
REQ-020 DONE SHALL go to LOAD with ld_count=0 on the edge after ld_restart=1.
REQ-021 If ld_restart=1 in LOAD, ld_count SHALL go to 0, any byte offered that cycle SHALL be discarded, and the state SHALL remain LOAD; restart wins over acceptance.
REQ-022 mem_ready SHALL be 1 exactly when the state is DONE.
REQ-023 The read path SHALL be combinational from rd_addr, with zero latency.
REQ-024 Byte i of the window (i=0..9) SHALL be mem[rd_addr+i] if rd_addr+i < ld_count; otherwise it SHALL be 8'h00, which decodes as halt.
REQ-025 rd_error SHALL be 1 if rd_addr >= MEM_BYTES or mem_ready=0; otherwise it SHALL be 0.
REQ-026 When rd_error=1, rd_data SHALL be 80'h10_00000000_00000000_00, a nop byte followed by zeros, matching fetch's bubble icode.
REQ-027 Window bytes whose address is >= MEM_BYTES SHALL read 8'h00 without wrap-around.
REQ-028 Address arithmetic SHALL be 64-bit, and an overflow of rd_addr+i SHALL be treated as out of range.

Reset
REQ-029 While reset=1, the state SHALL be LOAD, ld_count=0, ld_ready=0, and mem_ready=0, and no memory write SHALL occur.
REQ-030 After reset deasserts, ld_ready SHALL rise combinationally; the first byte can be accepted on the first clock edge.
REQ-031 Memory contents SHALL NOT be cleared by reset; they are masked via ld_count under REQ-024.
REQ-032 A reset asserted mid-load SHALL abort the load immediately; previously written bytes become unreadable until reloaded.

Verification
REQ-033 Load bytes 10 10 20 12 with ld_last on the 4th byte -> ld_count=4, mem_ready=1, and rd_addr=0 gives rd_data=80'h10102012_00000000_0000 with rd_error=0.
REQ-034 Hold ld_valid=0 for 3 cycles mid-load -> ld_count holds and no write occurs; on resume the next byte lands at the correct address.
REQ-035 Stream 1025 bytes with ld_last never asserted -> DONE after byte 1024, ld_ready=0, the 1025th byte is not accepted, and ld_count=1024.
REQ-036 After DONE, drive rd_addr=1020 -> bytes 1020-1023 are returned followed by six 00 bytes, with rd_error=0; drive rd_addr=1024 -> rd_error=1 and rd_data=nop pattern.
REQ-037 Assert reset after 5 bytes, then reload 2 bytes with ld_last -> ld_count=2, rd_addr=0 returns the 2 new bytes followed by 00s, and old bytes 2-4 read 00.
REQ-038 Assert ld_restart in the same cycle as an accepted byte during LOAD -> the byte is discarded, ld_count=0 next cycle, and mem_ready stays 0.
